// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, period states and small helpers for the period encoder.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic [SYM_W-1:0] CTL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTL_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] GB_EVEN = 10'b1011001100;
    localparam logic [SYM_W-1:0] GB_ODD  = 10'b0100110011;

    // Video preamble CTL pair (CTL1,CTL0) carried on lane 1
    localparam logic [1:0] PRE_CTL = 2'b01;

    typedef enum logic [1:0] {CTRL, PRE, GB, VID} period_e;

    function automatic logic [SYM_W-1:0] ctl_code(input logic [1:0] c);
        logic [SYM_W-1:0] s;
        case (c)
            2'b00:   s = CTL_00;
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            default: s = CTL_11;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane_encoder.sv
// One TMDS lane: stage 1 builds q_m and its popcount, stage 2 makes the DC-balance
// decision and registers the symbol. Non-video symbols travel the same two stages.
module tmds_lane_encoder
    import tmds_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             is_video,
    input  logic [1:0]       ctl,
    input  logic             force_sym_en,
    input  logic [SYM_W-1:0] force_sym,
    input  logic [7:0]       d,
    output logic [SYM_W-1:0] sym
);

    logic             use_xnor;
    logic             acc;
    logic [3:0]       n1_d;
    logic [8:0]       qm_d;
    logic [8:0]       qm_q;
    logic [3:0]       qn1_q;
    logic             vid_q;
    logic             frc_q;
    logic [1:0]       ctl_q;
    logic [SYM_W-1:0] fsym_q;

    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    logic signed [4:0] n1s;
    logic signed [4:0] n0s;
    logic signed [4:0] bal;
    logic signed [4:0] two;
    logic [SYM_W-1:0]  sym_d;

    always_comb begin
        n1_d     = popcount8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        acc      = d[0];
        qm_d     = '0;
        qm_d[0]  = acc;
        for (int i = 1; i < 8; i++) begin
            acc     = use_xnor ? ~(acc ^ d[i]) : (acc ^ d[i]);
            qm_d[i] = acc;
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            qm_q   <= '0;
            qn1_q  <= '0;
            vid_q  <= 1'b0;
            frc_q  <= 1'b0;
            ctl_q  <= 2'b00;
            fsym_q <= '0;
        end else begin
            qm_q   <= qm_d;
            qn1_q  <= popcount8(qm_d[7:0]);
            vid_q  <= is_video;
            frc_q  <= force_sym_en;
            ctl_q  <= ctl;
            fsym_q <= force_sym;
        end
    end

    always_comb begin
        n1s   = $signed({1'b0, qn1_q});
        n0s   = 5'sd8 - n1s;
        bal   = n1s - n0s;
        two   = qm_q[8] ? 5'sd2 : 5'sd0;
        sym_d = ctl_code(ctl_q);
        cnt_d = 5'sd0;
        if (!vid_q) begin
            if (frc_q) sym_d = fsym_q;
        end else if ((cnt_q == 5'sd0) || (bal == 5'sd0)) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
        end else if (((cnt_q > 5'sd0) && (bal > 5'sd0)) || ((cnt_q < 5'sd0) && (bal < 5'sd0))) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + two - bal;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q - (5'sd2 - two) + bal;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym   <= CTL_00;
            cnt_q <= 5'sd0;
        end else begin
            sym   <= sym_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tmds_period_encoder.sv
// Multi-lane TMDS encoder with optional HDMI video preamble and leading guard band,
// inserted by looking LEAD cycles ahead on the undelayed DE.
module tmds_period_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned NCH     = 3,
    parameter int unsigned PRE_LEN = 8,
    parameter int unsigned GB_LEN  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 hdmi_mode,
    input  logic                 de,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [8*NCH-1:0]     pixel,
    output logic [SYM_W*NCH-1:0] tmds,
    output logic                 de_out
);

    localparam int unsigned LEAD = PRE_LEN + GB_LEN;
    localparam int unsigned BW   = $clog2(2 * LEAD + 1);
    localparam int unsigned PW   = $clog2((PRE_LEN > GB_LEN) ? PRE_LEN : GB_LEN) + 1;

    logic [LEAD-1:0]  de_sr;
    logic [LEAD-1:0]  hs_sr;
    logic [LEAD-1:0]  vs_sr;
    logic [8*NCH-1:0] pix_sr [LEAD];
    logic             dly_de;
    logic             dly_hs;
    logic             dly_vs;
    logic [BW-1:0]    blank_q;
    logic             start;
    logic [PW-1:0]    ph_q;
    period_e          state_q;
    period_e          period;
    logic             vid1_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            de_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
            for (int i = 0; i < int'(LEAD); i++) pix_sr[i] <= '0;
        end else begin
            de_sr     <= {de_sr[LEAD-2:0], de};
            hs_sr     <= {hs_sr[LEAD-2:0], hsync};
            vs_sr     <= {vs_sr[LEAD-2:0], vsync};
            pix_sr[0] <= pixel;
            for (int i = 1; i < int'(LEAD); i++) pix_sr[i] <= pix_sr[i-1];
        end
    end

    assign dly_de = de_sr[LEAD-1];
    assign dly_hs = hs_sr[LEAD-1];
    assign dly_vs = vs_sr[LEAD-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= BW'(2 * LEAD);
        end else if (de) begin
            blank_q <= '0;
        end else if (blank_q != BW'(2 * LEAD)) begin
            blank_q <= blank_q + 1'b1;
        end
    end

    // A nonzero blank count also means the previous DE was low, so this doubles as edge detect
    assign start = hdmi_mode && de && (blank_q >= BW'(LEAD + 2));

    // Class of the sample currently leaving the delay line
    always_comb begin
        period = state_q;
        if (state_q == CTRL) begin
            if (start) period = PRE;
            else if (dly_de) period = VID;
        end else if ((state_q == VID) && !dly_de) begin
            period = CTRL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CTRL;
            ph_q    <= '0;
            vid1_q  <= 1'b0;
            de_out  <= 1'b0;
        end else begin
            vid1_q <= (period == VID);
            de_out <= vid1_q;
            unique case (period)
                CTRL: begin
                    state_q <= CTRL;
                    ph_q    <= '0;
                end
                PRE: begin
                    if (ph_q == PW'(PRE_LEN - 1)) begin
                        state_q <= GB;
                        ph_q    <= '0;
                    end else begin
                        state_q <= PRE;
                        ph_q    <= ph_q + 1'b1;
                    end
                end
                GB: begin
                    if (ph_q == PW'(GB_LEN - 1)) begin
                        state_q <= VID;
                        ph_q    <= '0;
                    end else begin
                        state_q <= GB;
                        ph_q    <= ph_q + 1'b1;
                    end
                end
                VID: begin
                    state_q <= VID;
                    ph_q    <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        logic [1:0] ctl;
        if (i == 0) begin : g_sync
            assign ctl = {dly_vs, dly_hs};
        end else if (i == 1) begin : g_pre
            assign ctl = (period == PRE) ? PRE_CTL : 2'b00;
        end else begin : g_idle
            assign ctl = 2'b00;
        end

        tmds_lane_encoder u_lane (
            .clock       (clock),
            .reset_n     (reset_n),
            .is_video    (period == VID),
            .ctl         (ctl),
            .force_sym_en(period == GB),
            .force_sym   ((i % 2 == 0) ? GB_EVEN : GB_ODD),
            .d           (pix_sr[LEAD-1][8*i +: 8]),
            .sym         (tmds[SYM_W*i +: SYM_W])
        );
    end

endmodule

// File: tb/tb_tmds_period_encoder.sv
// Directed bench for tmds_period_encoder built with four lanes; expected symbols hand-derived.
module tb_tmds_period_encoder;

    localparam int NCH = 4;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] GBE = 10'b1011001100;
    localparam logic [9:0] GBO = 10'b0100110011;

    // Lanes {3,2,1,0} carry pixels {0x01,0x55,0xFF,0x00}
    localparam logic [31:0] PIX = 32'h0155FF00;
    localparam logic [39:0] V0 = {10'b0111111111, 10'b0100110011, 10'b1000000000, 10'b0100000000};
    localparam logic [39:0] V1 = {10'b1100000000, 10'b0100110011, 10'b0011111111, 10'b1111111111};
    localparam logic [39:0] V2 = {10'b1100000000, 10'b0100110011, 10'b0011111111, 10'b0100000000};
    localparam logic [39:0] CTRL0 = {C00, C00, C00, C00};
    localparam logic [39:0] PREV  = {C00, C00, C01, C00};
    localparam logic [39:0] GBV   = {GBO, GBE, GBO, GBE};

    logic        clock;
    logic        reset_n;
    logic        hdmi_mode;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [31:0] pixel;
    logic [39:0] tmds;
    logic        de_out;

    int n_checks = 0;
    int n_errors = 0;

    tmds_period_encoder #(.NCH(NCH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .hdmi_mode(hdmi_mode),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .pixel    (pixel),
        .tmds     (tmds),
        .de_out   (de_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        hdmi_mode = 1'b0;
        de        = 1'b0;
        hsync     = 1'b0;
        vsync     = 1'b0;
        pixel     = '0;
        tick(3);
        check_eq("rst_tmds", tmds, CTRL0);
        check_eq("rst_de_out", de_out, 0);
        reset_n = 1'b1;

        // DVI sync control codes and exact latency
        hsync = 1'b1;
        tick(14);
        check_eq("dvi_hs", tmds, {C00, C00, C00, C01});
        for (int c = 0; c <= 12; c++) begin
            vsync = 1'b1;
            hsync = 1'b0;
            if (c == 11) check_eq("dvi_vs_early", tmds, {C00, C00, C00, C01});
            if (c == 12) check_eq("dvi_vs_lat", tmds, {C00, C00, C00, C10});
            tick();
        end

        // DVI video, three pixels
        vsync = 1'b0;
        tick(14);
        for (int c = 0; c <= 16; c++) begin
            de    = (c < 3);
            pixel = PIX;
            case (c)
                11: begin check_eq("dvi_pre_ctl", tmds, CTRL0); check_eq("dvi_pre_de", de_out, 0); end
                12: begin check_eq("dvi_v0", tmds, V0); check_eq("dvi_v0_de", de_out, 1); end
                13: check_eq("dvi_v1", tmds, V1);
                14: check_eq("dvi_v2", tmds, V2);
                15: begin check_eq("dvi_post", tmds, CTRL0); check_eq("dvi_post_de", de_out, 0); end
                default: ;
            endcase
            tick();
        end

        // HDMI: long blank then pulse, then a short gap with no preamble
        hdmi_mode = 1'b1;
        de        = 1'b0;
        tick(40);
        for (int c = 0; c <= 25; c++) begin
            de = (c <= 2) || (c >= 9 && c <= 11);
            case (c)
                1:  begin check_eq("h_before", tmds, CTRL0); check_eq("h_before_de", de_out, 0); end
                2:  check_eq("h_pre_first", tmds, PREV);
                9:  check_eq("h_pre_last", tmds, PREV);
                10: begin check_eq("h_gb0", tmds, GBV); check_eq("h_gb0_de", de_out, 0); end
                11: check_eq("h_gb1", tmds, GBV);
                12: begin check_eq("h_v0", tmds, V0); check_eq("h_v0_de", de_out, 1); end
                13: check_eq("h_v1", tmds, V1);
                14: check_eq("h_v2", tmds, V2);
                15: begin check_eq("h_end", tmds, CTRL0); check_eq("h_end_de", de_out, 0); end
                17: check_eq("short_no_pre", tmds, CTRL0);
                19: check_eq("short_no_gb", tmds, CTRL0);
                21: begin check_eq("short_v0", tmds, V0); check_eq("short_v0_de", de_out, 1); end
                22: check_eq("short_v1", tmds, V1);
                23: check_eq("short_v2", tmds, V2);
                24: begin check_eq("short_end", tmds, CTRL0); check_eq("short_end_de", de_out, 0); end
                default: ;
            endcase
            tick();
        end

        // Drop hdmi_mode while the guard band is being generated
        de = 1'b0;
        tick(40);
        for (int c = 0; c <= 35; c++) begin
            de        = (c < 2) || (c >= 22 && c < 24);
            hdmi_mode = (c < 8);
            case (c)
                2:  check_eq("tg_pre", tmds, PREV);
                10: check_eq("tg_gb0", tmds, GBV);
                11: check_eq("tg_gb1", tmds, GBV);
                12: begin check_eq("tg_v0", tmds, V0); check_eq("tg_v0_de", de_out, 1); end
                13: check_eq("tg_v1", tmds, V1);
                14: check_eq("tg_end", tmds, CTRL0);
                24: check_eq("tg_no_pre", tmds, CTRL0);
                32: begin check_eq("tg_no_gb", tmds, CTRL0); check_eq("tg_no_gb_de", de_out, 0); end
                33: check_eq("tg_ctl", tmds, CTRL0);
                34: begin check_eq("tg_dvi_v0", tmds, V0); check_eq("tg_dvi_de", de_out, 1); end
                35: check_eq("tg_dvi_v1", tmds, V1);
                default: ;
            endcase
            tick();
        end

        // Asynchronous reset in the middle of video
        de = 1'b0;
        tick(14);
        de = 1'b1;
        tick(16);
        check_eq("mid_vid_de", de_out, 1);
        #3 reset_n = 1'b0;
        #1;
        check_eq("async_rst_tmds", tmds, CTRL0);
        check_eq("async_rst_de", de_out, 0);
        de = 1'b0;
        tick(2);
        reset_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            check_eq("post_rst_ctl", {de_out, tmds}, {1'b0, CTRL0});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
